// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - ARM condition evaluation, NZCV flag register and write-strobe gating
// Flags are split into NZ and CV groups so logical ops can update NZ while preserving C/V.
module cond_logic #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       cond_pass;
  logic       cond_ex;
  logic [1:0] flag_write;
  logic       n_flag;
  logic       z_flag;
  logic       c_flag;
  logic       v_flag;

  assign n_flag = flags_q[3];
  assign z_flag = flags_q[2];
  assign c_flag = flags_q[1];
  assign v_flag = flags_q[0];

  // Condition is judged only against registered flags, never the current ALU result.
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = z_flag;
      4'b0001: cond_pass = ~z_flag;
      4'b0010: cond_pass = c_flag;
      4'b0011: cond_pass = ~c_flag;
      4'b0100: cond_pass = n_flag;
      4'b0101: cond_pass = ~n_flag;
      4'b0110: cond_pass = v_flag;
      4'b0111: cond_pass = ~v_flag;
      4'b1000: cond_pass = c_flag & ~z_flag;
      4'b1001: cond_pass = ~c_flag | z_flag;
      4'b1010: cond_pass = (n_flag == v_flag);
      4'b1011: cond_pass = (n_flag != v_flag);
      4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_pass = z_flag | (n_flag != v_flag);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // A bubble or reset forces the pass bit low, which in turn blocks every strobe and flag write.
  always_comb begin
    cond_ex    = en & ~reset & cond_pass;
    flag_write = FlagW & {2{cond_ex}};
    flags_d    = flags_q;
    if (flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAGS_RST;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS & cond_ex;
  assign RegWrite = RegW & cond_ex & ~NoWrite;
  assign MemWrite = MemW & cond_ex;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - directed self-checking bench for cond_logic
// Each task drives one scenario and compares outputs a few ns after the rising edge.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  int errors = 0;
  int checks = 0;

  cond_logic #(.FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] c,
                       input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic rw, input logic mw, input logic nw);
    reset = r; en = e; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
    #1;
  endtask

  // Hand-written truth table of the ARM condition codes.
  function automatic logic expect_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    if (c == 4'd0)  return z;
    if (c == 4'd1)  return !z;
    if (c == 4'd2)  return cy;
    if (c == 4'd3)  return !cy;
    if (c == 4'd4)  return n;
    if (c == 4'd5)  return !n;
    if (c == 4'd6)  return v;
    if (c == 4'd7)  return !v;
    if (c == 4'd8)  return cy && !z;
    if (c == 4'd9)  return !cy || z;
    if (c == 4'd10) return n ~^ v;
    if (c == 4'd11) return n ^ v;
    if (c == 4'd12) return !z && (n ~^ v);
    if (c == 4'd13) return z || (n ^ v);
    if (c == 4'd14) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load_flags(input logic [3:0] f);
    drive(0, 1, 4'b1110, f, 2'b11, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_strobes cycle %0d: got %b expected 0000", i,
                 {CondEx, PCSrc, RegWrite, MemWrite});
      end
    end
    drive(0, 0, 4'b1110, 4'b1111, 2'b00, 0, 0, 0, 0);
    checks++;
    if (Flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", Flags);
    end
  endtask

  task automatic test_cond_sweep();
    logic exp;
    for (int f = 0; f < 16; f++) begin
      load_flags(f[3:0]);
      checks++;
      if (Flags !== f[3:0]) begin
        errors++;
        $display("FAIL sweep_preload: got %b expected %b", Flags, f[3:0]);
      end
      for (int c = 0; c < 16; c++) begin
        drive(0, 1, c[3:0], 4'b0000, 2'b00, 1, 1, 1, 0);
        exp = expect_pass(c[3:0], f[3:0]);
        checks++;
        if ({CondEx, PCSrc, RegWrite, MemWrite} !== {4{exp}}) begin
          errors++;
          $display("FAIL sweep flags=%b cond=%b: got %b expected %b", f[3:0], c[3:0],
                   {CondEx, PCSrc, RegWrite, MemWrite}, {4{exp}});
        end
      end
    end
  endtask

  task automatic test_partial_write();
    load_flags(4'b0000);
    drive(0, 1, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0);
    tick();
    checks++;
    if (Flags !== 4'b1100) begin
      errors++;
      $display("FAIL partial_nz: got %b expected 1100", Flags);
    end
    drive(0, 1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0);
    tick();
    checks++;
    if (Flags !== 4'b1100) begin
      errors++;
      $display("FAIL partial_cv_zero: got %b expected 1100", Flags);
    end
    drive(0, 1, 4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0);
    tick();
    checks++;
    if (Flags !== 4'b1111) begin
      errors++;
      $display("FAIL partial_cv_set: got %b expected 1111", Flags);
    end
  endtask

  task automatic test_failed_cond();
    load_flags(4'b0000);
    drive(0, 1, 4'b0000, 4'b0100, 2'b11, 1, 1, 1, 0);
    checks++;
    if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin
      errors++;
      $display("FAIL failcond_strobes: got %b expected 0000",
               {CondEx, PCSrc, RegWrite, MemWrite});
    end
    tick();
    checks++;
    if (Flags !== 4'b0000) begin
      errors++;
      $display("FAIL failcond_flags: got %b expected 0000", Flags);
    end
  endtask

  task automatic test_back_to_back();
    load_flags(4'b0000);
    // CMP setting Z; flags must not change within the same cycle.
    drive(0, 1, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1);
    checks++;
    if ({CondEx, RegWrite, Flags} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL b2b_cmp1: got condex=%b regwrite=%b flags=%b expected 1 0 0000",
               CondEx, RegWrite, Flags);
    end
    tick();
    drive(0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
    checks++;
    if (PCSrc !== 1'b1) begin
      errors++;
      $display("FAIL b2b_beq_taken: got %b expected 1", PCSrc);
    end
    drive(0, 1, 4'b1110, 4'b0000, 2'b11, 0, 1, 0, 1);
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cmp2: got regwrite=%b expected 0", RegWrite);
    end
    tick();
    drive(0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
    checks++;
    if (PCSrc !== 1'b0) begin
      errors++;
      $display("FAIL b2b_beq_not_taken: got %b expected 0", PCSrc);
    end
    // Flag-setting EQ instruction that clears Z: passes on old Z, writes new flags.
    load_flags(4'b0100);
    drive(0, 1, 4'b0000, 4'b0010, 2'b11, 0, 1, 0, 0);
    checks++;
    if ({CondEx, RegWrite} !== 2'b11) begin
      errors++;
      $display("FAIL selfref_pass: got %b expected 11", {CondEx, RegWrite});
    end
    tick();
    checks++;
    if (Flags !== 4'b0010) begin
      errors++;
      $display("FAIL selfref_flags: got %b expected 0010", Flags);
    end
  endtask

  task automatic test_bubble_and_reset();
    load_flags(4'b0101);
    drive(0, 0, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 0);
    checks++;
    if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin
      errors++;
      $display("FAIL bubble_strobes: got %b expected 0000",
               {CondEx, PCSrc, RegWrite, MemWrite});
    end
    tick();
    checks++;
    if (Flags !== 4'b0101) begin
      errors++;
      $display("FAIL bubble_flags: got %b expected 0101", Flags);
    end
    drive(0, 0, 4'bxxxx, 4'b1010, 2'b11, 1, 1, 1, 0);
    checks++;
    if (CondEx !== 1'b0) begin
      errors++;
      $display("FAIL bubble_x_condex: got %b expected 0", CondEx);
    end
    tick();
    checks++;
    if (Flags !== 4'b0101) begin
      errors++;
      $display("FAIL bubble_x_flags: got %b expected 0101", Flags);
    end
    load_flags(4'b1010);
    drive(1, 1, 4'b1110, 4'b0101, 2'b11, 1, 1, 1, 0);
    checks++;
    if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_strobes: got %b expected 0000",
               {CondEx, PCSrc, RegWrite, MemWrite});
    end
    tick();
    drive(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    checks++;
    if (Flags !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_flags: got %b expected 0000", Flags);
    end
  endtask

  initial begin
    test_reset();
    test_cond_sweep();
    test_partial_write();
    test_failed_cond();
    test_back_to_back();
    test_bubble_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
